// File: rtl/riscv_md_unit.sv
// PCPI multiply/divide coprocessor for the RV32M/RV64M instructions.
// Multiplies by iterative shift-add and divides by restoring division.
module riscv_md_unit #(
  parameter int XLEN      = 32,
  parameter int MUL_BITS  = 2,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            wr,
  output logic [XLEN-1:0] rd,
  output logic            busy,
  output logic            ready
);

  localparam int NM = XLEN / MUL_BITS;
  localparam int CW = $clog2(XLEN);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_MUL   = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_FIXUP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg2_if(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic [2*XLEN-1:0] prod_q, prod_d;

  // Decode and operand sign capture for the incoming request
  logic [2:0]      f3;
  logic            match, sgn_a_in, sgn_b_in, sa_in, sb_in, div0_in, ovf_in;
  logic            unused_bits;

  assign f3       = instruction[14:12];
  assign match    = (instruction[6:0] == 7'b0110011) && (instruction[31:25] == 7'b0000001);
  assign sgn_a_in = f3[2] ? ~f3[0] : (f3 != 3'd3);
  assign sgn_b_in = f3[2] ? ~f3[0] : ~f3[1];
  assign sa_in    = sgn_a_in & rs1[XLEN-1];
  assign sb_in    = sgn_b_in & rs2[XLEN-1];
  assign div0_in  = (rs2 == '0);
  assign ovf_in   = f3[2] & ~f3[0] & (rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (rs2 == '1);

  // Iteration datapath, working on magnitudes of the latched operands
  logic [XLEN-1:0]          mcand, divisor;
  logic [XLEN+MUL_BITS-1:0] partial, msum;
  logic [2*XLEN-1:0]        mul_next, div_next;
  logic [XLEN:0]            shifted;
  logic [XLEN+1:0]          trial;
  logic                     fits;

  assign mcand    = neg_if(a_q, sa_q);
  assign divisor  = neg_if(b_q, sb_q);
  assign partial  = {{MUL_BITS{1'b0}}, mcand} * {{XLEN{1'b0}}, prod_q[MUL_BITS-1:0]};
  assign msum     = {{MUL_BITS{1'b0}}, prod_q[2*XLEN-1:XLEN]} + partial;
  assign mul_next = {msum, prod_q[XLEN-1:MUL_BITS]};

  assign shifted  = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign fits     = ~trial[XLEN+1];
  assign div_next = {(fits ? trial[XLEN-1:0] : shifted[XLEN-1:0]), prod_q[XLEN-2:0], fits};

  assign unused_bits = ^{instruction[24:15], instruction[11:7], trial[XLEN]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    prod_d  = prod_q;
    case (state_q)
      S_IDLE: begin
        if (valid && match) begin
          op_d = f3;
          a_d  = rs1;
          b_d  = rs2;
          sa_d = sa_in;
          sb_d = sb_in;
          if (f3[2]) begin
            if (EARLY_OUT && (div0_in || ovf_in)) begin
              // Results are preloaded as magnitudes; FIXUP applies the signs
              prod_d  = div0_in ? {neg_if(rs1, sa_in), {XLEN{1'b1}}} : {{XLEN{1'b0}}, rs1};
              state_d = S_FIXUP;
            end else begin
              prod_d  = {{XLEN{1'b0}}, neg_if(rs1, sa_in)};
              cnt_d   = CW'(XLEN - 1);
              state_d = S_DIV;
            end
          end else begin
            prod_d  = {{XLEN{1'b0}}, neg_if(rs2, sb_in)};
            cnt_d   = CW'(NM - 1);
            state_d = S_MUL;
          end
        end
      end
      S_MUL, S_DIV: begin
        if (!valid) begin
          state_d = S_IDLE;
        end else begin
          prod_d = (state_q == S_MUL) ? mul_next : div_next;
          if (cnt_q == '0) state_d = S_FIXUP;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_FIXUP: begin
        if (!valid) begin
          state_d = S_IDLE;
        end else begin
          if (op_q[2]) begin
            prod_d = {neg_if(prod_q[2*XLEN-1:XLEN], sa_q),
                      neg_if(prod_q[XLEN-1:0], (sa_q ^ sb_q) && (b_q != '0))};
          end else begin
            prod_d = neg2_if(prod_q, sa_q ^ sb_q);
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      prod_q  <= prod_d;
    end
  end

  // MUL, DIV and DIVU return the low half; high products and remainders the high half
  always_comb begin
    ready = (state_q == S_DONE);
    wr    = ready;
    busy  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIXUP) || (state_q == S_DONE);
    rd    = '0;
    if (ready) begin
      if ((op_q == 3'd0) || (op_q == 3'd4) || (op_q == 3'd5)) rd = prod_q[XLEN-1:0];
      else                                                   rd = prod_q[2*XLEN-1:XLEN];
    end
  end

endmodule

// File: tb/tb_riscv_md_unit.sv
// Directed bench for riscv_md_unit (XLEN=32, MUL_BITS=2, EARLY_OUT=1).
module tb_riscv_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] instruction;
  logic [31:0] rs1, rs2;
  logic        wr, busy, ready;
  logic [31:0] rd;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       nm;
  } vec_t;

  vec_t tv[$];

  riscv_md_unit #(.XLEN(32), .MUL_BITS(2), .EARLY_OUT(1'b1)) dut (
    .clk(clk), .reset(reset), .valid(valid), .instruction(instruction),
    .rs1(rs1), .rs2(rs2), .wr(wr), .rd(rd), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm);
    int cyc;
    int busy_low;
    bit seen;
    @(negedge clk);
    instruction = mk(f3, 7'b0000001);
    rs1 = a;
    rs2 = b;
    valid = 1'b1;
    cyc = 0;
    busy_low = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) begin
        rs1 = $urandom;
        rs2 = $urandom;
      end
      if (!busy) busy_low++;
      if (ready) seen = 1'b1;
    end
    chk({nm, " ready"}, 64'(seen), 64'd1);
    chk({nm, " latency"}, 64'(cyc), 64'(lat));
    chk({nm, " rd"}, 64'(rd), 64'(exp));
    chk({nm, " wr"}, 64'(wr), 64'd1);
    chk({nm, " busy-gap"}, 64'(busy_low), 64'd0);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " hold-outputs"}, 64'({busy, ready, wr, rd}), 64'd0);
  endtask

  initial begin
    int cnt;
    int cyc;
    tv.push_back('{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 18, "MUL 7*-3"});
    tv.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, "MULH min*min"});
    tv.push_back('{3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 18, "MULHU 2^31*2^31"});
    tv.push_back('{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 18, "MULHSU -1*2"});
    tv.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 18, "MULH -1*-1"});
    tv.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 18, "MULHU max*max"});
    tv.push_back('{3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 18, "MUL ffff*ffff"});
    tv.push_back('{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34, "DIV -7/2"});
    tv.push_back('{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34, "REM -7/2"});
    tv.push_back('{3'd5, 32'd100,       32'd7,         32'd14,        34, "DIVU 100/7"});
    tv.push_back('{3'd7, 32'd100,       32'd7,         32'd2,         34, "REMU 100/7"});
    tv.push_back('{3'd4, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 34, "DIV min/1"});
    tv.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "REMU 2^31/max"});
    tv.push_back('{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,  "DIVU 5/0"});
    tv.push_back('{3'd6, 32'd5,         32'd0,         32'd5,         2,  "REM 5/0"});
    tv.push_back('{3'd4, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 2,  "DIV -7/0"});
    tv.push_back('{3'd6, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 2,  "REM -7/0"});
    tv.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  "DIV overflow"});
    tv.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,  "REM overflow"});

    reset = 1'b1;
    valid = 1'b0;
    instruction = 32'h0;
    rs1 = 32'h0;
    rs2 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 64'({busy, ready, wr, rd}), 64'd0);
    reset = 1'b0;

    foreach (tv[i]) run_op(tv[i].f3, tv[i].a, tv[i].b, tv[i].exp, tv[i].lat, tv[i].nm);

    // Valid dropped during cycle 10 of a divide
    @(negedge clk);
    instruction = mk(3'd4, 7'b0000001);
    rs1 = 32'd100;
    rs2 = 32'd7;
    valid = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort busy before drop", 64'(busy), 64'd1);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort busy after drop", 64'(busy), 64'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready || wr) cnt++;
    end
    chk("abort no ready", 64'(cnt), 64'd0);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "DIVU after abort");

    // Reset asserted in cycle 5 of a multiply
    @(negedge clk);
    instruction = mk(3'd0, 7'b0000001);
    rs1 = 32'd7;
    rs2 = 32'd3;
    valid = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("busy before reset", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk("async reset outputs", 64'({busy, ready, wr, rd}), 64'd0);
    valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(3'd0, 32'd7, 32'd3, 32'd21, 18, "MUL after reset");

    // Valid held through ready: HOLD must not re-accept
    @(negedge clk);
    instruction = mk(3'd0, 7'b0000001);
    rs1 = 32'd6;
    rs2 = 32'd9;
    valid = 1'b1;
    cyc = 0;
    while (!ready && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    chk("b2b latency", 64'(cyc), 64'd18);
    chk("b2b rd", 64'(rd), 64'd54);
    @(posedge clk);
    @(negedge clk);
    chk("b2b hold busy/ready", 64'({busy, ready}), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b idle busy", 64'(busy), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b re-accept busy", 64'(busy), 64'd1);
    valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b abort busy", 64'(busy), 64'd0);

    // Non-M instruction (funct7=0) must be ignored
    @(negedge clk);
    instruction = mk(3'd0, 7'b0000000);
    rs1 = 32'd5;
    rs2 = 32'd5;
    valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy || ready || wr) cnt++;
    end
    chk("non-M ignored", 64'(cnt), 64'd0);
    valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_md_unit.md
RISCV_MD_UNIT -- requirements
Module: riscv_md_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter MUL_BITS, default 2, multiplier bits retired per cycle; legal values 1, 2, 4 and 8, and it SHALL divide XLEN.
REQ-003 Parameter EARLY_OUT, default 1; when 1, the division by zero and signed-overflow cases SHALL bypass iteration.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 valid  input  1  PCPI request; held high by the core until ready or until it abandons the request.
REQ-007 instruction  input  32  PCPI instruction word.
REQ-008 rs1  input  XLEN  first operand.
REQ-009 rs2  input  XLEN  second operand.
REQ-010 wr  output  1  result write-enable; 1-cycle pulse coincident with ready.
REQ-011 rd  output  XLEN  result; valid only while ready=1, and 0 otherwise.
REQ-012 busy  output  1  high while an accepted instruction is in flight.
REQ-013 ready  output  1  completion pulse, 1 cycle wide.

Function
REQ-014 Decode SHALL match opcode 0110011 and funct7 0000001; funct3 0-7 SHALL map to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-015 Non-matching instructions SHALL be ignored: state stays IDLE, busy=ready=wr=0.
REQ-016 FSM states SHALL be IDLE, MUL, DIV, FIXUP, DONE and HOLD.
REQ-017 Accept: in IDLE with valid=1 and a match, the block SHALL latch the operands, the operation, and the operand signs per op signedness, then enter MUL or DIV next cycle; this is cycle 0.
REQ-018 Magnitudes SHALL be formed from the latched operands as absolute values for signed ops and passed unchanged for unsigned ops; MULHSU SHALL treat only rs1 as signed.
REQ-019 MUL: shift-add on magnitudes with MUL_BITS bits per cycle for NM=XLEN/MUL_BITS cycles into a 2*XLEN product register; then go to FIXUP.
REQ-020 DIV: restoring division, 1 quotient bit per cycle, for XLEN cycles; then go to FIXUP.
REQ-021 An iteration counter SHALL count down from the iteration count to 0; the exit condition is counter==0 at the end of a cycle.
REQ-022 FIXUP (1 cycle): the product SHALL be negated if the operand signs differ; the quotient SHALL be negated if the signs differ and the divisor is nonzero; the remainder SHALL take the sign of the dividend.
REQ-023 DONE (1 cycle): ready=1, wr=1, and rd equals the low XLEN bits (MUL) or high XLEN bits (MULH*) of the product, the quotient, or the remainder.
REQ-024 Latency: ready SHALL assert at cycle NM+2 for multiply and XLEN+2 for divide.
REQ-025 Divide by zero: the quotient SHALL be all ones and the remainder SHALL be rs1 unchanged, for both signed and unsigned ops.
REQ-026 Signed overflow (rs1=-2^(XLEN-1), rs2=-1, DIV/REM): the quotient SHALL be -2^(XLEN-1) and the remainder SHALL be 0.
REQ-027 With EARLY_OUT=1, the REQ-025 and REQ-026 cases SHALL go from accept straight to FIXUP, giving ready at cycle 2.
REQ-028 busy SHALL be 1 in MUL, DIV, FIXUP and DONE, and 0 in IDLE and HOLD.
REQ-029 If valid drops in MUL, DIV or FIXUP, the block SHALL return to IDLE next cycle with no ready or wr pulse and the result discarded.
REQ-030 After DONE the block SHALL spend exactly 1 cycle in HOLD, ignoring valid, then return to IDLE; this prevents re-accepting the instruction just completed.
REQ-031 Operand changes on rs1, rs2 or instruction after accept SHALL NOT affect the result.

Reset
REQ-032 reset=1 SHALL asynchronously force IDLE with busy=ready=wr=0, rd=0, and the counter and datapath registers cleared.
REQ-033 Reset mid-operation SHALL abort with no ready pulse; the first accept after reset deasserts SHALL behave as from power-up.

Verification (XLEN=32, MUL_BITS=2, EARLY_OUT=1)
REQ-034 MUL rs1=7, rs2=0xFFFFFFFD -> rd=0xFFFFFFEB, wr=ready=1 at cycle 18, busy high cycles 1-18.
REQ-035 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU on the same operands -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD at cycle 34; REM on the same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-037 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM on the same operands -> 0; all of these give ready at cycle 2.
REQ-038 Abort: valid dropped at cycle 10 of a DIV -> no ready; reset asserted at cycle 5 of a MUL -> all outputs 0 immediately; a following accept completes correctly.
REQ-039 Back-to-back: valid held high through ready -> no second accept during HOLD; a non-M instruction (funct7=0) -> busy stays 0 indefinitely.
